// File: rtl/iobus_out_demux_6.sv
// Write-side demux for the MCU I/O bus: steers one write into one of six registered
// output ports, each with a load strobe and a pending/acknowledge handshake.
module iobus_out_demux_6 #(
   parameter int unsigned N = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         WR_VALID,
   input  logic [2:0]   WR_SEL,
   input  logic [N-1:0] WR_DATA,
   output logic         WR_READY,
   input  logic [5:0]   ACK,
   output logic [N-1:0] D0,
   output logic [N-1:0] D1,
   output logic [N-1:0] D2,
   output logic [N-1:0] D3,
   output logic [N-1:0] D4,
   output logic [N-1:0] D5,
   output logic [5:0]   STB,
   output logic [5:0]   PEND,
   output logic         ERR,
   output logic [7:0]   ERR_CNT,
   input  logic         ERR_CLR
);

   localparam int unsigned NumPorts = 6;

   logic [N-1:0] data_q [NumPorts];
   logic [N-1:0] data_d [NumPorts];
   logic [5:0]   stb_q, stb_d;
   logic [5:0]   pend_q, pend_d;
   logic         err_q, err_d;
   logic [7:0]   err_cnt_q, err_cnt_d;

   logic         sel_valid;
   logic [5:0]   sel_oh;
   logic         port_busy;
   logic         accept;
   logic         drop;
   logic [5:0]   wr_oh;

   // Selects 6 and 7 decode to no port, so they never see back-pressure.
   always_comb begin
      sel_valid = (WR_SEL < 3'd6);
      sel_oh    = sel_valid ? (6'b000001 << WR_SEL) : 6'b000000;
      port_busy = |(sel_oh & pend_q & ~ACK);
      WR_READY  = !RST && !port_busy;
      accept    = WR_VALID && WR_READY;
      drop      = accept && !sel_valid;
      wr_oh     = accept ? sel_oh : 6'b000000;
   end

   always_comb begin
      stb_d  = wr_oh;
      pend_d = (pend_q & ~ACK) | wr_oh;
      for (int k = 0; k < NumPorts; k++) begin
         data_d[k] = wr_oh[k] ? WR_DATA : data_q[k];
      end
   end

   // A drop coinciding with ERR_CLR restarts the count at one.
   always_comb begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      if (drop) begin
         err_d = 1'b1;
         if (ERR_CLR) begin
            err_cnt_d = 8'd1;
         end else if (err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end else if (ERR_CLR) begin
         err_d     = 1'b0;
         err_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < NumPorts; k++) begin
            data_q[k] <= '0;
         end
         stb_q     <= '0;
         pend_q    <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         for (int k = 0; k < NumPorts; k++) begin
            data_q[k] <= data_d[k];
         end
         stb_q     <= stb_d;
         pend_q    <= pend_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign D0      = data_q[0];
   assign D1      = data_q[1];
   assign D2      = data_q[2];
   assign D3      = data_q[3];
   assign D4      = data_q[4];
   assign D5      = data_q[5];
   assign STB     = stb_q;
   assign PEND    = pend_q;
   assign ERR     = err_q;
   assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_iobus_out_demux_6.sv
// Bench for iobus_out_demux_6: directed vector table, hand sequences and random traffic,
// all checked every cycle against a port-level reference model.
module tb_iobus_out_demux_6;

   logic       CLK = 1'b0;
   logic       RST, WR_VALID, ERR_CLR;
   logic [2:0] WR_SEL;
   logic [7:0] WR_DATA;
   logic [5:0] ACK;
   logic       WR_READY;
   logic [7:0] D0, D1, D2, D3, D4, D5;
   logic [5:0] STB, PEND;
   logic       ERR;
   logic [7:0] ERR_CNT;

   iobus_out_demux_6 #(.N(8)) dut (
      .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_SEL(WR_SEL), .WR_DATA(WR_DATA),
      .WR_READY(WR_READY), .ACK(ACK), .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4),
      .D5(D5), .STB(STB), .PEND(PEND), .ERR(ERR), .ERR_CNT(ERR_CNT), .ERR_CLR(ERR_CLR)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state, one entry per port.
   int m_d [6];
   bit m_pend [6];
   bit m_stb [6];
   bit m_err;
   int m_cnt;

   function automatic int dut_d(input int k);
      case (k)
         0: return int'(D0);
         1: return int'(D1);
         2: return int'(D2);
         3: return int'(D3);
         4: return int'(D4);
         default: return int'(D5);
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_ready(input bit rst, input int sel, input logic [5:0] ack);
      if (rst) return 1'b0;
      if (sel > 5) return 1'b1;
      return !m_pend[sel] || ack[sel];
   endfunction

   // One clock: drive inputs, check READY, clock, advance model, check all state.
   task automatic cycle(input bit rst, input bit valid, input int sel, input int data,
                        input logic [5:0] ack, input bit clr);
      bit rdy, acc;
      RST = rst; WR_VALID = valid; WR_SEL = 3'(sel); WR_DATA = 8'(data);
      ACK = ack; ERR_CLR = clr;
      #1;
      rdy = model_ready(rst, sel, ack);
      chk("wr_ready", int'(WR_READY), int'(rdy));
      acc = valid && rdy;
      if (rst) begin
         for (int k = 0; k < 6; k++) begin
            m_d[k] = 0; m_pend[k] = 0; m_stb[k] = 0;
         end
         m_err = 0; m_cnt = 0;
      end else begin
         for (int k = 0; k < 6; k++) begin
            m_stb[k] = acc && (sel == k);
            if (ack[k]) m_pend[k] = 0;
            if (m_stb[k]) begin
               m_pend[k] = 1;
               m_d[k] = data;
            end
         end
         if (acc && sel > 5) begin
            m_err = 1;
            m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         end else if (clr) begin
            m_err = 0;
            m_cnt = 0;
         end
      end
      @(posedge CLK);
      #1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("d%0d", k), dut_d(k), m_d[k]);
         chk($sformatf("stb%0d", k), int'(STB[k]), int'(m_stb[k]));
         chk($sformatf("pend%0d", k), int'(PEND[k]), int'(m_pend[k]));
      end
      chk("err", int'(ERR), int'(m_err));
      chk("err_cnt", int'(ERR_CNT), m_cnt);
   endtask

   typedef struct {
      bit         valid;
      int         sel;
      int         data;
      logic [5:0] ack;
      bit         exp_ready;
      logic [5:0] exp_stb;
      logic [5:0] exp_pend;
   } vec_t;

   vec_t tbl [9];

   initial begin
      for (int k = 0; k < 6; k++) begin
         m_d[k] = 0; m_pend[k] = 0; m_stb[k] = 0;
      end
      m_err = 0; m_cnt = 0;
      RST = 1; WR_VALID = 0; WR_SEL = 0; WR_DATA = 0; ACK = 0; ERR_CLR = 0;

      // Reset, and a write held off while RST is high.
      cycle(1, 0, 0, 0, 6'h00, 0);
      cycle(1, 1, 2, 8'h5a, 6'h00, 0);
      chk("rst_no_write_d2", int'(D2), 0);

      tbl[0] = '{1, 3, 8'ha5, 6'h00, 1, 6'b001000, 6'b001000};
      tbl[1] = '{0, 0, 8'h00, 6'h00, 1, 6'b000000, 6'b001000};
      tbl[2] = '{0, 0, 8'h00, 6'h08, 1, 6'b000000, 6'b000000};
      tbl[3] = '{1, 0, 8'h01, 6'h00, 1, 6'b000001, 6'b000001};
      tbl[4] = '{1, 5, 8'h02, 6'h00, 1, 6'b100000, 6'b100001};
      tbl[5] = '{1, 2, 8'h03, 6'h00, 1, 6'b000100, 6'b100101};
      tbl[6] = '{0, 0, 8'h00, 6'h00, 0, 6'b000000, 6'b100101};
      tbl[7] = '{1, 5, 8'h44, 6'h20, 1, 6'b100000, 6'b100101};
      tbl[8] = '{0, 0, 8'h00, 6'h3f, 1, 6'b000000, 6'b000000};
      for (int i = 0; i < 9; i++) begin
         RST = 0; WR_VALID = tbl[i].valid; WR_SEL = 3'(tbl[i].sel);
         ACK = tbl[i].ack; #1;
         chk($sformatf("tbl%0d_ready", i), int'(WR_READY), int'(tbl[i].exp_ready));
         cycle(0, tbl[i].valid, tbl[i].sel, tbl[i].data, tbl[i].ack, 0);
         chk($sformatf("tbl%0d_stb", i), int'(STB), int'(tbl[i].exp_stb));
         chk($sformatf("tbl%0d_pend", i), int'(PEND), int'(tbl[i].exp_pend));
         if (i == 0) chk("tbl0_d3", int'(D3), 8'ha5);
         if (i == 7) chk("tbl7_d5", int'(D5), 8'h44);
      end

      // Back-pressure on port 1.
      cycle(0, 1, 1, 8'h11, 6'h00, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 1, 8'h22, 6'h00, 0);
         chk("bp_d1_held", int'(D1), 8'h11);
      end
      WR_VALID = 1; WR_SEL = 3'd1; ACK = 6'h02; #1;
      chk("bp_ready_on_ack", int'(WR_READY), 1);
      cycle(0, 1, 1, 8'h22, 6'h02, 0);
      chk("bp_d1_new", int'(D1), 8'h22);
      chk("bp_pend1", int'(PEND[1]), 1);
      cycle(0, 0, 0, 0, 6'h3f, 0);

      // Drops saturate the counter; a clear with a drop restarts it at one.
      for (int i = 0; i < 300; i++) cycle(0, 1, 7, i, 6'h00, 0);
      chk("drop_err", int'(ERR), 1);
      chk("drop_cnt_sat", int'(ERR_CNT), 255);
      cycle(0, 1, 6, 8'h99, 6'h00, 1);
      chk("clr_drop_cnt", int'(ERR_CNT), 1);
      cycle(0, 0, 0, 0, 6'h00, 1);
      chk("clr_cnt", int'(ERR_CNT), 0);

      // Reset in the middle of every handshake.
      for (int k = 0; k < 6; k++) cycle(0, 1, k, 8'h80 + k, 6'h00, 0);
      chk("all_pend", int'(PEND), 6'h3f);
      cycle(0, 1, 7, 0, 6'h00, 0);
      cycle(1, 1, 3, 8'h77, 6'h00, 0);
      chk("rst_pend", int'(PEND), 0);
      chk("rst_cnt", int'(ERR_CNT), 0);
      WR_VALID = 1; WR_SEL = 3'd4; ACK = 0; RST = 0; #1;
      chk("post_rst_ready", int'(WR_READY), 1);
      cycle(0, 1, 4, 8'hc4, 6'h00, 0);
      chk("post_rst_d4", int'(D4), 8'hc4);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0), $urandom_range(0, 3) != 0,
               int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
               6'($urandom & $urandom), ($urandom_range(0, 49) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/iobus_out_demux_6.md
# iobus_out_demux_6

Write-side counterpart of the Otter 6-to-1 input-select mux. It takes one write request from the MCU I/O bus and steers the data word into one of six registered output ports. Each port has a one-cycle load strobe and a pending/acknowledge handshake, so a slow peripheral cannot lose a word. Writes to unused selects (6, 7) are dropped and counted. It sits between the MCU IOBUS write path and up to six output peripherals (LEDs, seven-segment display, timer, and so on).

## Interface
- n, 8, data width of the write bus and of each output port
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- WR_VALID  in  1  write request valid
- WR_SEL  in  3  target port; 0–5 are valid, 6–7 are unused
- WR_DATA  in  n  write data
- WR_READY  out  1  request accepted this cycle when high together with WR_VALID
- ACK  in  6  per-port acknowledge from the peripheral; bit k belongs to port k
- D0..D5  out  n each  registered port data
- STB  out  6  per-port one-cycle load strobe
- PEND  out  6  per-port flag: data loaded and not yet acknowledged
- ERR  out  1  sticky flag: a write to an unused select occurred
- ERR_CNT  out  8  saturating count of dropped writes
- ERR_CLR  in  1  clears ERR and ERR_CNT

## Operation
- Reset (RST=1 at a clock edge):
  - D0..D5 = 0, STB = 0, PEND = 0, ERR = 0, ERR_CNT = 0.
  - WR_READY is forced to 0 while RST=1.
  - A reset in the middle of any handshake discards all pending state; there is no replay.
- WR_READY is combinational and equals !RST && (WR_SEL>5 || !PEND[WR_SEL] || ACK[WR_SEL]).
- Accept: WR_VALID && WR_READY, with WR_SEL=k and k≤5.
  - Dk <= WR_DATA.
  - STB[k] <= 1 for exactly one cycle.
  - PEND[k] <= 1.
  - All other ports are unchanged.
- Stall: WR_VALID=1 while PEND[k]=1 and ACK[k]=0. WR_READY is 0, nothing is written, and the master holds WR_SEL and WR_DATA stable.
- Drop: accepted write with WR_SEL of 6 or 7.
  - No port changes.
  - ERR <= 1.
  - ERR_CNT increments and saturates at 255.
- ACK[k]=1 with PEND[k]=1: PEND[k] <= 0 at the next edge.
- ACK[k] with PEND[k]=0 is ignored.
- ACK on several ports in one cycle: each port is handled independently.
- Accept to port k and ACK[k] in the same cycle: the write proceeds. PEND[k] stays 1 because the new word is pending, STB[k] pulses, and Dk takes the new data.
- ERR_CLR:
  - ERR <= 0 and ERR_CNT <= 0.
  - If ERR_CLR coincides with a drop, the drop wins: ERR=1, ERR_CNT=1.
- STB is 0 on every cycle that does not follow an accept for that port.
- Dk holds its value indefinitely between writes and is not cleared by ACK.

## Timing
- WR_READY has zero latency: it is combinational from RST, WR_SEL, PEND and ACK.
- Accept at edge t gives new Dk, STB[k]=1 and PEND[k]=1 in the cycle after edge t. STB[k] returns to 0 after the next edge unless another accept to port k occurs.
- ACK to PEND clear takes 1 cycle.
- Sustained throughput:
  - Different ports: one write per cycle.
  - Same port: one write per cycle only if the peripheral asserts ACK on every cycle that PEND is high. Otherwise one write per ACK.
- ERR and ERR_CNT update one cycle after the dropped write.
- There is no combinational path from WR_DATA to any output.

## Test plan
- Reset, then check outputs and READY with RST held high.
  - After reset: D0..D5=0, STB=0, PEND=0, ERR=0, ERR_CNT=0.
  - With RST held at 1 and WR_VALID=1, SEL=2: WR_READY=0 and no write occurs.
- Single write: SEL=3, DATA=0xA5, VALID for 1 cycle.
  - Next cycle: D3=0xA5, STB=6'b001000 for one cycle, PEND[3]=1, other D unchanged.
  - Pulse ACK[3]: PEND[3]=0 one cycle later.
- Back-pressure: write 0x11 to port 1 with no ACK, then VALID with SEL=1, DATA=0x22.
  - WR_READY stays 0 for 5 cycles and D1 stays 0x11.
  - Assert ACK[1] in the 6th cycle: WR_READY=1 that cycle, D1=0x22 next cycle, PEND[1] stays 1.
- Back-to-back writes to ports 0, 5, 2 with DATA 0x01, 0x02, 0x03 on consecutive cycles.
  - All three accept with no stall.
  - STB pulses appear in order 0, 5, 2 on consecutive cycles.
  - Final state: PEND=6'b100101.
- Drops: 300 writes with SEL=7.
  - No D, STB or PEND changes; ERR=1, ERR_CNT=255.
  - ERR_CLR together with one SEL=6 write gives ERR=1, ERR_CNT=1.
- Reset mid-handshake: PEND=6'b111111, then assert RST for one cycle.
  - All PEND, D, ERR and ERR_CNT return to 0.
  - A write to port 4 on the next cycle accepts immediately.
